strobe_fifo: RTL and testbench
==============================

STROBE_FIFO -- requirements
Module: strobe_fifo

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits (1..32).
REQ-002 Parameter: DEPTH, default 4, entry count; power of two, 2..16; AW = log2(DEPTH).
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: strobe_in  input  1  one-cycle push pulse, e.g. the strobe_out of a clock-crossing strobe stage; no backpressure.
REQ-006 Port: data_in  input  WIDTH  word captured when strobe_in=1.
REQ-007 Port: valid_out  output  1  head entry available.
REQ-008 Port: ready_in  input  1  consumer accepts the head entry.
REQ-009 Port: data_out  output  WIDTH  head entry.
REQ-010 Port: level  output  AW+1  current occupancy, 0..DEPTH.
REQ-011 Port: clear_overflow  input  1  clears the overflow and drop_count state.
REQ-012 Port: overflow  output  1  sticky; set when a push is dropped.
REQ-013 Port: drop_count  output  8  saturating count of dropped pushes.

Function
REQ-014 Storage SHALL be a DEPTH-entry register array with AW-bit write and read pointers that wrap modulo DEPTH.
REQ-015 Push SHALL occur on a clock edge where strobe_in=1 and (level<DEPTH or pop occurs in the same cycle).
REQ-016 Pop SHALL occur on a clock edge where valid_out=1 and ready_in=1; the read pointer advances by 1.
REQ-017 valid_out SHALL equal (level!=0); data_out SHALL equal the array entry at the read pointer (combinational read of registered storage).
REQ-018 Latency: a strobe at edge N into an empty FIFO SHALL give valid_out=1 with that word on data_out after edge N; no same-cycle bypass.
REQ-019 Push and pop at the same edge SHALL leave level unchanged and advance both pointers, including at level=DEPTH and at level=1.
REQ-020 level SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-021 A strobe_in at level=DEPTH without a same-cycle pop SHALL be dropped; storage and pointers SHALL be unchanged.
REQ-022 ready_in while valid_out=0 SHALL have no effect.
REQ-023 Word ordering SHALL be strictly FIFO; no entry is lost or duplicated except by drop.

Reset
REQ-024 While reset_n=0, the block SHALL set pointers=0, level=0, valid_out=0, all storage entries=0 (data_out=0), overflow=0 and drop_count=0.
REQ-025 Deasserting reset_n mid-operation SHALL discard all buffered words; the first edge after release SHALL accept a push normally.

Configuration
REQ-026 Macro STROBE_FIFO_OVERFLOW_EN defined: overflow SHALL set on each dropped push; drop_count SHALL increment on each dropped push, saturating at 255.
REQ-027 With the macro defined: clear_overflow=1 SHALL zero overflow and drop_count at the next edge; a drop in the same cycle SHALL win, giving overflow=1 and drop_count=1.
REQ-028 Macro not defined: overflow and drop_count SHALL be constant 0, clear_overflow SHALL be ignored, and no counter logic SHALL be synthesised; drop behaviour per REQ-021 is unchanged.

Verification
REQ-029 Basic push/pop: DEPTH=4, ready_in=0, one strobe with data_in=0xA5 -> next cycle valid_out=1, data_out=0xA5, level=1; then ready_in=1 for one cycle -> valid_out=0, level=0.
REQ-030 Fill and order: strobes with 0x01..0x04 -> level=4; drain with ready_in=1 -> data_out 0x01,0x02,0x03,0x04 on consecutive cycles.
REQ-031 Overflow (macro defined): full with 0x01..0x04, strobe 0x05 with ready_in=0 -> level stays 4, overflow=1, drop_count=1, drained order 0x01..0x04; 300 further drops -> drop_count=255.
REQ-032 Full with simultaneous pop: full with 0x01..0x04, strobe 0x05 with ready_in=1 -> level=4, drained order 0x02,0x03,0x04,0x05, overflow=0.
REQ-033 Clear vs drop: overflow=1 with drop_count=7, then clear_overflow=1 in the same cycle as a dropped strobe -> overflow=1, drop_count=1.
REQ-034 Reset mid-operation: level=3, assert reset_n=0 asynchronously between edges -> valid_out=0, level=0 and data_out=0 immediately; after release, strobe 0x3C -> data_out=0x3C, level=1.

Source files
------------

// File: rtl/strobe_fifo.sv
// Strobe-fed FIFO: single-cycle pushes with no backpressure, valid/ready pop side.
// Optional dropped-push tracking (overflow, drop_count) is enabled by STROBE_FIFO_OVERFLOW_EN.
module strobe_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             strobe_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [WIDTH-1:0] data_out,
   output logic [AW:0]      level,
   input  logic             clear_overflow,
   output logic             overflow,
   output logic [7:0]       drop_count
);

   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level_q;
   logic             full;
   logic             push;
   logic             pop;

   // Handshake: a word leaves on any edge where valid_out and ready_in are both 1;
   // valid_out never depends on ready_in, and ready_in while empty is ignored.
   // The strobe side has no ready: a strobe into a full FIFO is accepted only
   // when the head is popped on that same edge, otherwise it is dropped.
   assign full      = (level_q == FULL_LEVEL);
   assign valid_out = (level_q != '0);
   assign pop       = valid_out && ready_in;
   assign push      = strobe_in && (!full || pop);

   assign data_out  = mem[rd_ptr];
   assign level     = level_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= '0;
      end else begin
         case ({push, pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

`ifdef STROBE_FIFO_OVERFLOW_EN
   logic       drop;
   logic       overflow_q;
   logic [7:0] drop_count_q;

   assign drop = strobe_in && !push;

   // A drop on the same edge as a clear restarts the count at one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_q   <= 1'b0;
         drop_count_q <= 8'd0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (clear_overflow) begin
            drop_count_q <= 8'd1;
         end else if (drop_count_q != 8'hFF) begin
            drop_count_q <= drop_count_q + 8'd1;
         end
      end else if (clear_overflow) begin
         overflow_q   <= 1'b0;
         drop_count_q <= 8'd0;
      end
   end

   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
`else
   logic unused_clear_overflow;

   assign unused_clear_overflow = clear_overflow;
   assign overflow              = 1'b0;
   assign drop_count            = 8'd0;
`endif

endmodule

// File: tb/tb_strobe_fifo.sv
// Directed and random checks of strobe_fifo (DEPTH=4, WIDTH=8) against a queue-based model.
module tb_strobe_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AW    = $clog2(DEPTH);
`ifdef STROBE_FIFO_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic             clk;
   logic             reset_n;
   logic             strobe_in;
   logic [WIDTH-1:0] data_in;
   logic             valid_out;
   logic             ready_in;
   logic [WIDTH-1:0] data_out;
   logic [AW:0]      level;
   logic             clear_overflow;
   logic             overflow;
   logic [7:0]       drop_count;

   logic [WIDTH-1:0] exp_q[$];
   int               m_level;
   logic             m_ovf;
   int               m_cnt;
   int               n_checks;
   int               n_fail;

   strobe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .strobe_in      (strobe_in),
      .data_in        (data_in),
      .valid_out      (valid_out),
      .ready_in       (ready_in),
      .data_out       (data_out),
      .level          (level),
      .clear_overflow (clear_overflow),
      .overflow       (overflow),
      .drop_count     (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
   endtask

   // One clock: inputs driven just after an edge, outputs checked at the negedge,
   // model advanced just after the following posedge.
   task automatic cycle(input logic s, input logic [7:0] d, input logic r, input logic c);
      logic m_pop;
      logic m_push;
      logic m_drop;
      logic [WIDTH-1:0] exp_d;
      strobe_in      = s;
      data_in        = d;
      ready_in       = r;
      clear_overflow = c;
      @(negedge clk);
      check("level", level, m_level);
      check("valid_out", valid_out, m_level != 0);
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_cnt);
      m_pop  = (m_level != 0) && r;
      m_push = s && ((m_level < DEPTH) || m_pop);
      m_drop = s && !m_push;
      if (m_pop) begin
         exp_d = exp_q.pop_front();
         check("data_out", data_out, exp_d);
      end
      @(posedge clk);
      #1;
      if (m_push) exp_q.push_back(d);
      m_level = m_level + int'(m_push) - int'(m_pop);
      if (OVF_EN) begin
         if (m_drop) begin
            m_ovf = 1'b1;
            if (c) m_cnt = 1;
            else if (m_cnt < 255) m_cnt = m_cnt + 1;
         end else if (c) begin
            m_ovf = 1'b0;
            m_cnt = 0;
         end
      end
   endtask

   task automatic fill4();
      for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      reset_n        = 1'b0;
      strobe_in      = 1'b0;
      data_in        = '0;
      ready_in       = 1'b0;
      clear_overflow = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check("rst valid_out", valid_out, 1'b0);
      check("rst level", level, 0);
      check("rst data_out", data_out, 8'h00);
      check("rst overflow", overflow, 1'b0);
      check("rst drop_count", drop_count, 8'd0);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // single push then pop
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      check("push valid_out", valid_out, 1'b1);
      check("push data_out", data_out, 8'hA5);
      check("push level", level, 1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("pop valid_out", valid_out, 1'b0);
      check("pop level", level, 0);

      // fill and ordered drain
      fill4();
      check("fill level", level, 4);
      check("fill head", data_out, 8'h01);
      drain(4);
      check("drained level", level, 0);

      // drop while full, then saturation
      fill4();
      cycle(1'b1, 8'h05, 1'b0, 1'b0);
      check("drop level", level, 4);
      check("drop overflow", overflow, OVF_EN ? 1 : 0);
      check("drop drop_count", drop_count, OVF_EN ? 1 : 0);
      drain(4);
      fill4();
      for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      check("sat drop_count", drop_count, OVF_EN ? 255 : 0);
      drain(4);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check("clear overflow", overflow, 1'b0);
      check("clear drop_count", drop_count, 8'd0);

      // full with simultaneous pop accepts the strobe
      fill4();
      cycle(1'b1, 8'h05, 1'b1, 1'b0);
      check("full+pop level", level, 4);
      check("full+pop overflow", overflow, 1'b0);
      check("full+pop head", data_out, 8'h02);
      drain(4);

      // clear and drop on the same edge
      fill4();
      for (int i = 0; i < 7; i++) cycle(1'b1, 8'h77, 1'b0, 1'b0);
      check("seven drop_count", drop_count, OVF_EN ? 7 : 0);
      cycle(1'b1, 8'h99, 1'b0, 1'b1);
      check("clr+drop overflow", overflow, OVF_EN ? 1 : 0);
      check("clr+drop drop_count", drop_count, OVF_EN ? 1 : 0);
      drain(4);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // ready while empty is ignored
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("empty ready level", level, 0);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      end
      drain(DEPTH);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // asynchronous reset mid-operation
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      check("pre-reset level", level, 3);
      strobe_in = 1'b0;
      ready_in  = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("async rst valid_out", valid_out, 1'b0);
      check("async rst level", level, 0);
      check("async rst data_out", data_out, 8'h00);
      check("async rst overflow", overflow, 1'b0);
      check("async rst drop_count", drop_count, 8'd0);
      model_reset();
      @(negedge clk);
      #2;
      strobe_in = 1'b1;
      data_in   = 8'h3C;
      reset_n   = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(8'h3C);
      m_level = 1;
      check("post-rst data_out", data_out, 8'h3C);
      check("post-rst level", level, 1);
      check("post-rst valid_out", valid_out, 1'b1);
      drain(1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check("final queue empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
